// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed 16x16 multiplier.
// Holds the controller state encoding and the operand/product widths.
package mult_pkg;

  localparam int unsigned MUL_W     = 16;
  localparam int unsigned MUL_STEPS = 16;
  localparam int unsigned PROD_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_row_step.sv
// One row of the signed array multiplier, reused once per multiplier bit.
// Ports:
//   x        - multiplicand (signed)
//   y_bit    - current multiplier bit
//   acc      - running partial-product high part (17-bit signed)
//   last     - sign row: subtract the multiplicand instead of adding
//   acc_next - partial sum arithmetically shifted right by one
//   z        - product bit retired by this row
module mult_row_step
  import mult_pkg::*;
(
  input  logic [MUL_W-1:0] x,
  input  logic             y_bit,
  input  logic [MUL_W:0]   acc,
  input  logic             last,
  output logic [MUL_W:0]   acc_next,
  output logic             z
);

  logic [MUL_W:0] x_ext;
  logic [MUL_W:0] addend;
  logic           cin;
  logic [MUL_W:0] sum;

  // Negation in the sign row is invert plus carry-in; the 17-bit sum never wraps.
  always_comb begin
    x_ext    = {x[MUL_W-1], x};
    addend   = y_bit ? (last ? ~x_ext : x_ext) : '0;
    cin      = y_bit & last;
    sum      = acc + addend + (MUL_W+1)'(cin);
    acc_next = {sum[MUL_W], sum[MUL_W:1]};
    z        = sum[0];
  end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential controller for the signed 16x16 multiplier: one row step per
// clock for 16 clocks, last row in subtract mode, valid/ready on both sides.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - operand handshake (in_ready only in IDLE)
//   a, b                - signed multiplicand / multiplier
//   flush               - synchronous abort, discards any pending product
//   out_valid, out_ready- product handshake
//   product             - signed 32-bit product, held while out_valid
//   busy                - high while RUN, LAST or DONE
module mult16_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_W,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH:0]     acc;
  logic [CNT_W-1:0]   step;
  logic [WIDTH-1:0]   plo;

  logic               accept;
  logic               last;
  logic [WIDTH:0]     acc_next;
  logic               z;
  logic [WIDTH-1:0]   plo_next;

  mult_row_step u_row (
    .x        (x_r),
    .y_bit    (y_r[step]),
    .acc      (acc),
    .last     (last),
    .acc_next (acc_next),
    .z        (z)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition, including an accept.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last     = 1'b0;
    plo_next = plo;
    plo_next[step] = z;
    case (state_q)
      IDLE: begin
        accept = in_valid & ~flush;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (step == CNT_W'(WIDTH - 2)) state_d = LAST;
      end
      LAST: begin
        last    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r       <= '0;
      y_r       <= '0;
      acc       <= '0;
      step      <= '0;
      plo       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_r  <= a;
            y_r  <= b;
            acc  <= '0;
            step <= '0;
            plo  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_next;
          plo  <= plo_next;
          step <= step + 1'b1;
        end
        LAST: begin
          acc  <= acc_next;
          plo  <= plo_next;
          step <= '0;
          if (!flush) begin
            product   <= {acc_next[WIDTH-1:0], plo_next};
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
      if (flush) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed bench for mult16_seq_ctrl: hand-computed products, latency,
// backpressure, flush, mid-run reset and random pairs against a*b.
module tb_mult16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult16_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one pair, wait for the product, check latency and value, then drain.
  task automatic run_op(input logic [15:0] opa, input logic [15:0] opb,
                        input logic [31:0] exp, input string tag);
    int n;
    int rdy_seen;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = opa; b = opb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    n = 0; rdy_seen = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_no_ready_busy"}, 32'(rdy_seen | int'(in_ready)), 32'd0);
    check({tag, "_product"}, product, exp);
    tick();
  endtask

  initial begin
    int n;
    int sa;
    int sb;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] held;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", product, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(16'd3,    16'd5,    32'h0000000F, "p3x5");
    run_op(16'hFFFF, 16'd1,    32'hFFFFFFFF, "m1x1");
    run_op(16'd1,    16'hFFFF, 32'hFFFFFFFF, "p1xm1");
    run_op(16'h8000, 16'h8000, 32'h40000000, "minxmin");
    run_op(16'h7FFF, 16'h8000, 32'hC0008000, "maxxmin");
    run_op(16'h1234, 16'h0000, 32'h00000000, "bzero");

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    out_ready = 1'b0;
    a = 16'h7FFF; b = 16'h7FFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("bp_latency", 32'(n), 32'd16);
    check("bp_product", product, 32'h3FFF0001);
    held = product;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_product", product, 32'h3FFF0001);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    a = 16'd6; b = 16'hFFFE; in_valid = 1'b1;
    tick();
    check("bp_drained_valid", 32'(out_valid), 32'd0);
    check("bp_drained_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_taken", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("bp_next_latency", 32'(n), 32'd16);
    check("bp_next_product", product, 32'hFFFFFFF4);
    tick();

    // Flush at step 7: back to IDLE, no product.
    a = 16'd100; b = 16'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("flush_no_valid", 32'(n), 32'd0);

    // flush together with in_valid in IDLE: nothing accepted.
    a = 16'd2; b = 16'd2; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept_busy", 32'(busy), 32'd0);
    check("flush_vs_accept_ready", 32'(in_ready), 32'd1);

    run_op(16'hFFF9, 16'd9, 32'hFFFFFFC1, "m7x9");

    // Reset pulse mid-RUN.
    a = 16'd50; b = 16'd50; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", product, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("midrst_no_valid", 32'(n), 32'd0);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      run_op(ra, rb, 32'(sa * sb), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult16_seq_ctrl.md
Name: mult16_seq_ctrl

Overview:
- Sequential controller for the signed 16x16 array-multiplier row datapath.
- Reuses one row-step slice for 16 cycles, one cycle per multiplier bit, instead of instantiating 16 rows.
- The final (sign) row is executed in subtract mode, which gives a two's-complement product.
- Sits between the CPU execute stage and the multiply result mux; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand width; the design and test plan are fixed to 16 and other values are not supported.
- CNT_W, 4, step-counter width, equal to log2(WIDTH).

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- in_valid, in, 1, operand pair valid.
- in_ready, out, 1, controller can accept operands; high only in IDLE.
- a, in, 16, multiplicand X, signed.
- b, in, 16, multiplier Y, signed.
- flush, in, 1, synchronous abort of any operation in progress.
- out_valid, out, 1, product valid.
- out_ready, in, 1, consumer accepts product.
- product, out, 32, signed product a*b.
- busy, out, 1, high in RUN, LAST or DONE.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following clear:
  - state goes to IDLE;
  - acc, step and all capture registers go to 0;
  - out_valid=0, product=0, busy=0, in_ready=1 (from the next cycle on).
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch x_r=a, y_r=b, acc=17'b0, step=0, plo=0, then go to RUN.
- Row step (combinational slice, one per clock in RUN/LAST):
  - Addend: 0 when y_r[step]=0; sext17(x_r) in RUN; -sext17(x_r) in LAST (two's complement: invert plus carry-in 1).
  - sum = acc + addend, 17 bits, wrap-free by construction.
  - Z = sum[0] is written to plo[step].
  - acc <= {sum[16], sum[16:1]} (arithmetic shift right).
- State RUN:
  - Steps 0..14; step increments every cycle.
  - When step==14 completes, go to LAST with step=15.
- State LAST:
  - Executes step 15 in subtract mode.
  - Then product <= {acc_next[15:0], plo_next}, out_valid <= 1, go to DONE.
- State DONE:
  - product is held stable while out_valid=1.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency and throughput:
  - Accept edge to out_valid=1 is 16 cycles (15 RUN + 1 LAST).
  - With out_ready held high, the next operand pair is accepted 2 cycles after out_valid rises (DONE -> IDLE -> accept).
- Handshake rules:
  - in_ready is never high while busy.
  - a and b are ignored outside the accept cycle.
  - product must not change while out_valid=1 and out_ready=0; backpressure is unbounded.
- flush:
  - In any state, forces state to IDLE and clears out_valid the next cycle; a pending product is discarded.
  - flush and in_valid in the same IDLE cycle: flush wins, nothing is accepted.
- Reset mid-operation behaves identically to flush plus clearing of all registers.
- Boundary values:
  - a=-32768 or b=-32768 produces the exact result; there is no overflow at 32 bits.
  - b=0 yields 0 after the full 16 cycles; there is no early termination.

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, RUN, LAST, DONE};
  - constants MUL_W=16, MUL_STEPS=16, PROD_W=32.
- Sub-module mult_row_step: purely combinational.
  - Inputs: x[15:0], y_bit, acc[16:0], last.
  - Outputs: acc_next[16:0], z.
  - Instantiated once; the controller owns all registers.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid exactly 16 cycles after the accept edge, product=0x0000000F; in_ready=0 throughout.
- a=-1 (0xFFFF), b=1 -> product=0xFFFFFFFF; a=1, b=-1 -> product=0xFFFFFFFF (LAST subtract path).
- a=0x8000, b=0x8000 -> 0x40000000; a=0x7FFF, b=0x8000 -> 0xC0008000; a=0x7FFF, b=0x7FFF -> 0x3FFF0001.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product and out_valid stay stable, in_ready stays 0. Then raise out_ready -> accepted, and a new in_valid is taken 2 cycles later.
- flush asserted at step 7 -> IDLE next cycle, out_valid never rises, in_ready=1. A following a=-7, b=9 returns 0xFFFFFFC1.
- rst_n=0 for 1 cycle mid-RUN -> all outputs at reset values next cycle. Then 200 random signed pairs -> each product matches the a*b reference model.
